// File: rtl/cache_set_ctrl.sv
// cache_set_ctrl: sequences core load/store requests onto one cache Set and fills it from memory on read misses.
// Define CACHE_SET_CTRL_STATS_EN to add the stat_hits/stat_misses/stat_errs counters.
module cache_set_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int TAG_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [TAG_W+11:0]  req_addr,
  input  logic [1:0]         req_size,
  input  logic [63:0]        req_wdata,
  output logic               rsp_valid,
  output logic               rsp_hit,
  output logic               rsp_err,
  output logic [63:0]        rsp_data,
  output logic [1:0]         set_enable,
  output logic [2:0]         set_write_en,
  output logic [5:0]         set_block_offset,
  output logic [5:0]         set_n,
  output logic [63:0]        set_write_data,
  output logic [1:0]         set_data_size,
  output logic [TAG_W-1:0]   set_tag,
  input  logic [127:0]       set_out_data,
  input  logic               set_miss_r,
  input  logic               set_miss_w,
  input  logic               set_data_ready,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [TAG_W+11:0]  mem_req_addr,
  input  logic               mem_rsp_valid,
  input  logic [63:0]        mem_rsp_data,
  output logic               busy
`ifdef CACHE_SET_CTRL_STATS_EN
  ,
  output logic [31:0]        stat_hits,
  output logic [31:0]        stat_misses,
  output logic [31:0]        stat_errs
`endif
);
  localparam int AW = TAG_W + 12;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, MEMREQ, MEMWAIT, FILL, FILLWAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0] size_q, size_d;
  logic write_q, write_d;
  logic [63:0] fill_q, fill_d;
  logic [7:0] cnt_q, cnt_d;
  logic req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d, rsp_hit_q, rsp_hit_d, rsp_err_q, rsp_err_d;
  logic [63:0] rsp_data_q, rsp_data_d, set_write_data_q, set_write_data_d;
  logic [1:0] set_enable_q, set_enable_d, set_data_size_q, set_data_size_d;
  logic [2:0] set_write_en_q, set_write_en_d;
  logic [5:0] set_block_offset_q, set_block_offset_d, set_n_q, set_n_d;
  logic [TAG_W-1:0] set_tag_q, set_tag_d;
  logic mem_req_valid_q, mem_req_valid_d, busy_q, busy_d;
  logic [AW-1:0] mem_req_addr_q, mem_req_addr_d;
  logic mis, timeout, to_issue, to_fill, unused_hi;
  // Low offset bits that must be zero for each access size: 0:none 1:[0] 2:[1:0] 3:[2:0]
  assign mis = |(req_addr[2:0] & {&req_size, req_size[1], |req_size});
  assign timeout = cnt_q == 8'(TIMEOUT);
  assign unused_hi = ^set_out_data[127:64];
  function automatic logic [63:0] extract(input logic [63:0] w, input logic [2:0] off, input logic [1:0] sz);
    logic [63:0] s;
    s = w >> {off, 3'b000};
    return s & (sz == 2'd0 ? 64'hFF : sz == 2'd1 ? 64'hFFFF : sz == 2'd2 ? 64'hFFFF_FFFF : {64{1'b1}});
  endfunction
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    size_d = size_q;
    write_d = write_q;
    fill_d = fill_q;
    rsp_hit_d = 1'b0;
    rsp_err_d = 1'b0;
    rsp_data_d = '0;
    cnt_d = (state_q == WAIT || state_q == FILLWAIT) ? cnt_q + {7'd0, cnt_q != 8'hFF} : 8'd0;
    case (state_q)
      IDLE: if (req_valid && req_ready_q) begin
        addr_d = req_addr;
        size_d = req_size;
        write_d = req_write;
        state_d = mis ? RESP : ISSUE;
        rsp_err_d = mis;
      end
      ISSUE: state_d = WAIT;
      WAIT: if (set_miss_r && !write_q) state_d = MEMREQ;
      else if (set_data_ready) begin
        state_d = RESP;
        rsp_hit_d = ~(set_miss_r | set_miss_w);
        rsp_data_d = write_q ? 64'd0 : extract(set_out_data[63:0], addr_q[2:0], size_q);
      end else if (timeout) begin
        state_d = RESP;
        rsp_err_d = 1'b1;
      end
      MEMREQ: if (mem_req_ready) state_d = MEMWAIT;
      MEMWAIT: if (mem_rsp_valid) begin
        state_d = FILL;
        fill_d = mem_rsp_data;
      end
      FILL: state_d = FILLWAIT;
      FILLWAIT: if (set_data_ready) begin
        state_d = RESP;
        rsp_data_d = extract(fill_q, addr_q[2:0], size_q);
      end else if (timeout) begin
        state_d = RESP;
        rsp_err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered, so they are derived from the state being entered
    to_issue = state_d == ISSUE;
    to_fill = state_d == FILL;
    req_ready_d = state_d == IDLE;
    busy_d = state_d != IDLE;
    rsp_valid_d = state_d == RESP;
    set_enable_d = {1'b0, to_issue || to_fill};
    set_write_en_d = to_issue ? {2'b00, req_write} : to_fill ? 3'd1 : 3'd2;
    set_block_offset_d = to_issue ? req_addr[5:0] : to_fill ? {addr_q[5:3], 3'b000} : set_block_offset_q;
    set_n_d = to_issue ? req_addr[11:6] : to_fill ? addr_q[11:6] : set_n_q;
    set_tag_d = to_issue ? req_addr[AW-1:12] : to_fill ? addr_q[AW-1:12] : set_tag_q;
    set_write_data_d = to_issue ? req_wdata : to_fill ? mem_rsp_data : set_write_data_q;
    set_data_size_d = to_issue ? req_size : to_fill ? 2'd3 : set_data_size_q;
    mem_req_valid_d = state_d == MEMREQ;
    mem_req_addr_d = mem_req_valid_d ? {addr_q[AW-1:3], 3'b000} : mem_req_addr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      size_q <= '0;
      write_q <= 1'b0;
      fill_q <= '0;
      cnt_q <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_data_q <= '0;
      set_enable_q <= '0;
      set_write_en_q <= 3'd2;
      set_block_offset_q <= '0;
      set_n_q <= '0;
      set_tag_q <= '0;
      set_write_data_q <= '0;
      set_data_size_q <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      size_q <= size_d;
      write_q <= write_d;
      fill_q <= fill_d;
      cnt_q <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q <= rsp_hit_d;
      rsp_err_q <= rsp_err_d;
      rsp_data_q <= rsp_data_d;
      set_enable_q <= set_enable_d;
      set_write_en_q <= set_write_en_d;
      set_block_offset_q <= set_block_offset_d;
      set_n_q <= set_n_d;
      set_tag_q <= set_tag_d;
      set_write_data_q <= set_write_data_d;
      set_data_size_q <= set_data_size_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_addr_q <= mem_req_addr_d;
      busy_q <= busy_d;
    end
  end
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_hit = rsp_hit_q;
  assign rsp_err = rsp_err_q;
  assign rsp_data = rsp_data_q;
  assign set_enable = set_enable_q;
  assign set_write_en = set_write_en_q;
  assign set_block_offset = set_block_offset_q;
  assign set_n = set_n_q;
  assign set_tag = set_tag_q;
  assign set_write_data = set_write_data_q;
  assign set_data_size = set_data_size_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr = mem_req_addr_q;
  assign busy = busy_q;
`ifdef CACHE_SET_CTRL_STATS_EN
  logic [31:0] hits_q, hits_d, misses_q, misses_d, errs_q, errs_d;
  // Classified on the response pulse: error wins, then hit, otherwise miss
  always_comb begin
    hits_d = hits_q + 32'(rsp_valid_q && !rsp_err_q && rsp_hit_q);
    misses_d = misses_q + 32'(rsp_valid_q && !rsp_err_q && !rsp_hit_q);
    errs_d = errs_q + 32'(rsp_valid_q && rsp_err_q);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits_q <= '0;
      misses_q <= '0;
      errs_q <= '0;
    end else begin
      hits_q <= hits_d;
      misses_q <= misses_d;
      errs_q <= errs_d;
    end
  end
  assign stat_hits = hits_q;
  assign stat_misses = misses_q;
  assign stat_errs = errs_q;
`endif
endmodule

// File: tb/tb_cache_set_ctrl.sv
// tb_cache_set_ctrl: directed bench with a direct-mapped Set model, a delayed memory model and a response scoreboard.
module tb_cache_set_ctrl;
  localparam int TAG_W = 24;
  localparam int TIMEOUT = 255;
  localparam int AW = TAG_W + 12;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [1:0] req_size = '0;
  logic [63:0] req_wdata = '0;
  logic req_ready, rsp_valid, rsp_hit, rsp_err;
  logic [63:0] rsp_data;
  logic [1:0] set_enable;
  logic [2:0] set_write_en;
  logic [5:0] set_block_offset, set_n;
  logic [63:0] set_write_data;
  logic [1:0] set_data_size;
  logic [TAG_W-1:0] set_tag;
  logic [127:0] set_out_data = '0;
  logic set_miss_r = 1'b0, set_miss_w = 1'b0, set_data_ready = 1'b0;
  logic mem_req_valid, mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
  logic [AW-1:0] mem_req_addr;
  logic [63:0] mem_rsp_data = '0;
  logic busy;
`ifdef CACHE_SET_CTRL_STATS_EN
  logic [31:0] stat_hits, stat_misses, stat_errs;
`endif

  cache_set_ctrl #(.TIMEOUT(TIMEOUT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
    .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .set_enable(set_enable), .set_write_en(set_write_en), .set_block_offset(set_block_offset),
    .set_n(set_n), .set_write_data(set_write_data), .set_data_size(set_data_size), .set_tag(set_tag),
    .set_out_data(set_out_data), .set_miss_r(set_miss_r), .set_miss_w(set_miss_w),
    .set_data_ready(set_data_ready),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .busy(busy)
`ifdef CACHE_SET_CTRL_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_errs(stat_errs)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string t, input logic [63:0] o, input logic [63:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", t, o, e);
    end
  endtask

  // Direct-mapped Set model: one 64-bit line per set index, answers the cycle after an enable
  logic [63:0] line_data [64];
  logic [TAG_W-1:0] line_tag [64];
  logic line_v [64] = '{default: 1'b0};
  bit set_mute = 1'b0;
  always @(posedge clk) begin : set_model
    logic hit;
    set_data_ready <= 1'b0;
    set_miss_r <= 1'b0;
    set_miss_w <= 1'b0;
    if (set_enable == 2'd1 && !set_mute) begin
      hit = line_v[set_n] && line_tag[set_n] == set_tag;
      set_data_ready <= 1'b1;
      if (set_write_en == 3'd0) begin
        set_miss_r <= !hit;
        set_out_data <= {64'hDEAD_BEEF_0BAD_F00D, line_data[set_n]};
      end else if (set_write_en == 3'd1) begin
        set_miss_w <= !hit;
        if (!hit) begin
          line_v[set_n] = 1'b1;
          line_tag[set_n] = set_tag;
          line_data[set_n] = '0;
        end
        for (int i = 0; i < (1 << set_data_size); i++)
          line_data[set_n][8*(int'(set_block_offset[2:0])+i) +: 8] = set_write_data[8*i +: 8];
      end
    end
  end

  // Memory model: returns mem_word mem_delay cycles after an accepted request
  logic [63:0] mem_word = '0;
  int mem_delay = 2, mem_cnt = 0;
  always @(posedge clk) begin
    mem_rsp_valid <= 1'b0;
    if (mem_cnt > 0) begin
      mem_cnt <= mem_cnt - 1;
      if (mem_cnt == 1) begin
        mem_rsp_valid <= 1'b1;
        mem_rsp_data <= mem_word;
      end
    end else if (mem_req_valid && mem_req_ready) mem_cnt <= mem_delay;
  end

  typedef struct {string name; logic hit; logic err; logic [63:0] data;} exp_t;
  exp_t sb[$];
  int cyc = 0, rsp_cyc = 0, en_cnt = 0;
  logic [AW-1:0] last_mem_addr = '0;
  logic [5:0] fill_off = 6'h3F;
  logic [63:0] fill_data = '0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mem_req_valid) last_mem_addr = mem_req_addr;
    if (set_enable != 2'd0) en_cnt++;
    if (set_enable == 2'd1 && set_write_en == 3'd1 && set_data_size == 2'd3) begin
      fill_off = set_block_offset;
      fill_data = set_write_data;
    end
    if (rsp_valid) begin
      rsp_cyc = cyc;
      if (sb.size() == 0) chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
      else begin
        e = sb.pop_front();
        chk({e.name, "_hit"}, 64'(rsp_hit), 64'(e.hit));
        chk({e.name, "_err"}, 64'(rsp_err), 64'(e.err));
        chk({e.name, "_data"}, rsp_data, e.data);
      end
    end
  end

  function automatic logic [AW-1:0] mk(input int tag, input int set, input int off);
    return {TAG_W'(tag), 6'(set), 6'(off)};
  endfunction
  task automatic push(input string n, input logic h, input logic e, input logic [63:0] d);
    exp_t x;
    x.name = n;
    x.hit = h;
    x.err = e;
    x.data = d;
    sb.push_back(x);
  endtask
  task automatic send(input logic wr, input logic [AW-1:0] a, input logic [1:0] sz, input logic [63:0] wd, output int acc);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr = a;
    req_size = sz;
    req_wdata = wd;
    @(negedge clk);
    acc = cyc;
    req_valid = 1'b0;
  endtask
  task automatic wait_rsp(input string t);
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk({t, "_rsp_seen"}, 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, n, en0;
    logic [AW-1:0] held;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_set_write_en", 64'(set_write_en), 64'd2);
    chk("rst_set_enable", 64'(set_enable), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", 64'(req_ready), 64'd1);
    // Store to an empty line is a write miss; the reload then hits
    push("st_a5", 1'b0, 1'b0, 64'd0);
    send(1'b1, mk(16, 0, 0), 2'd0, 64'hA5, acc);
    wait_rsp("st_a5");
    push("ld_a5", 1'b1, 1'b0, 64'hA5);
    send(1'b0, mk(16, 0, 0), 2'd0, 64'd0, acc);
    wait_rsp("ld_a5");
    chk("ld_hit_latency", 64'(rsp_cyc - acc + 1), 64'd3);
    // Read miss with fill
    mem_word = 64'h1122334455667788;
    mem_delay = 2;
    mem_req_ready = 1'b1;
    push("rd_miss", 1'b0, 1'b0, 64'h11223344);
    send(1'b0, mk(19, 0, 4), 2'd2, 64'd0, acc);
    wait_rsp("rd_miss");
    chk("mem_req_addr", 64'(last_mem_addr), 64'(mk(19, 0, 0)));
    chk("fill_offset", 64'(fill_off), 64'd0);
    chk("fill_data", fill_data, 64'h1122334455667788);
    push("ld_fill_h16", 1'b1, 1'b0, 64'h1122);
    send(1'b0, mk(19, 0, 6), 2'd1, 64'd0, acc);
    wait_rsp("ld_fill_h16");
    push("ld_fill_d64", 1'b1, 1'b0, 64'h1122334455667788);
    send(1'b0, mk(19, 0, 0), 2'd3, 64'd0, acc);
    wait_rsp("ld_fill_d64");
    // Misaligned accesses never touch the Set
    en0 = en_cnt;
    push("mis_ld64", 1'b0, 1'b1, 64'd0);
    send(1'b0, mk(19, 0, 2), 2'd3, 64'd0, acc);
    wait_rsp("mis_ld64");
    chk("mis_latency_le2", 64'(rsp_cyc - acc + 1 <= 2), 64'd1);
    push("mis_st16", 1'b0, 1'b1, 64'd0);
    send(1'b1, mk(19, 0, 3), 2'd1, 64'hFFFF, acc);
    wait_rsp("mis_st16");
    chk("mis_no_set_enable", 64'(en_cnt), 64'(en0));
    // Timeout: ISSUE cycle plus TIMEOUT+1 WAIT cycles
    set_mute = 1'b1;
    push("timeout", 1'b0, 1'b1, 64'd0);
    send(1'b0, mk(16, 0, 0), 2'd0, 64'd0, acc);
    wait_rsp("timeout");
    chk("timeout_latency", 64'(rsp_cyc - acc), 64'(TIMEOUT + 2));
    chk("timeout_back_idle", 64'(req_ready), 64'd1);
    set_mute = 1'b0;
    // Memory backpressure, then reset in MEMWAIT with a fill still in flight
    mem_req_ready = 1'b0;
    mem_delay = 6;
    send(1'b0, mk(22, 5, 8), 2'd3, 64'd0, acc);
    n = 0;
    while (!mem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_mem_req_valid", 64'(mem_req_valid), 64'd1);
    held = mem_req_addr;
    chk("bp_addr_aligned", 64'(held), 64'(mk(22, 5, 8)));
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid_hold", 64'(mem_req_valid), 64'd1);
      chk("bp_addr_hold", 64'(mem_req_addr), 64'(held));
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("memwait_valid_low", 64'(mem_req_valid), 64'd0);
    chk("memwait_busy", 64'(busy), 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_req_ready", 64'(req_ready), 64'd0);
    chk("arst_set_write_en", 64'(set_write_en), 64'd2);
    chk("arst_set_tag", 64'(set_tag), 64'd0);
    chk("arst_mem_req_addr", 64'(mem_req_addr), 64'd0);
    chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);
    repeat (10) @(negedge clk);
    chk("stale_fill_ignored", 64'(busy), 64'd0);
    // 2 hits, 1 miss, 1 error after reset
    push("post_hit1", 1'b1, 1'b0, 64'h1122334455667788);
    send(1'b0, mk(19, 0, 0), 2'd3, 64'd0, acc);
    wait_rsp("post_hit1");
    push("post_hit2", 1'b1, 1'b0, 64'h55667788);
    send(1'b0, mk(19, 0, 0), 2'd2, 64'd0, acc);
    wait_rsp("post_hit2");
    push("post_st_miss", 1'b0, 1'b0, 64'd0);
    send(1'b1, mk(30, 9, 0), 2'd3, 64'hCAFE, acc);
    wait_rsp("post_st_miss");
    push("post_err", 1'b0, 1'b1, 64'd0);
    send(1'b0, mk(30, 9, 1), 2'd1, 64'd0, acc);
    wait_rsp("post_err");
`ifdef CACHE_SET_CTRL_STATS_EN
    chk("stat_hits", 64'(stat_hits), 64'd2);
    chk("stat_misses", 64'(stat_misses), 64'd1);
    chk("stat_errs", 64'(stat_errs), 64'd1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_set_ctrl.md
Name: cache_set_ctrl

Overview:
- Sequences single core load/store requests onto one cache Set instance.
- Splits the address into tag, set index and offset, and drives the Set's command pins.
- Waits for Set completion. On a read miss it fetches the aligned 64-bit word from memory, fills the Set, then responds.
- Sits between the core request port and the Set, with a simple memory port on the miss side.

Parameters:
- TIMEOUT, 255: max cycles waiting for Set completion before an error response.
- TAG_W, 24: tag width; address width = TAG_W + 12.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- req_valid  in  1  core request valid
- req_ready  out  1  controller accepts request
- req_write  in  1  1=store, 0=load
- req_addr  in  TAG_W+12  {tag, set[11:6], offset[5:0]}
- req_size  in  2  0:8b 1:16b 2:32b 3:64b
- req_wdata  in  64  store data, right-aligned
- rsp_valid  out  1  one-cycle response pulse
- rsp_hit  out  1  access hit in Set
- rsp_err  out  1  misaligned or timeout
- rsp_data  out  64  load data, zero-extended
- set_enable  out  2  Set enable
- set_write_en  out  3  0 read, 1 write, 2 no-op/readout
- set_block_offset  out  6  byte offset
- set_n  out  6  set index
- set_write_data  out  64  Set write data
- set_data_size  out  2  Set access size
- set_tag  out  TAG_W  Set tag
- set_out_data  in  128  Set read data; low 64 used
- set_miss_r  in  1  Set read miss
- set_miss_w  in  1  Set write miss
- set_data_ready  in  1  Set operation complete
- mem_req_valid  out  1  memory fetch request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  TAG_W+12  req_addr with [2:0]=0
- mem_rsp_valid  in  1  fill data valid
- mem_rsp_data  in  64  fill word
- busy  out  1  FSM not in IDLE

Behaviour:
- Interface: single clock clk; rst_n is asynchronous and active-low. All outputs are registered.
- Reset values: all outputs 0, except set_write_en=2. FSM enters IDLE. Counters clear.
- req_ready=1 only in IDLE. A transfer occurs on req_valid&&req_ready at a rising edge. The controller latches addr, size, write and wdata.
- Alignment check: misaligned when offset mod 2^size != 0.
  - Misaligned requests go IDLE->RESP with rsp_err=1, rsp_hit=0, rsp_data=0.
  - The Set is not touched in this case.
- States and transitions:
  - IDLE: wait for an accepted request.
  - ISSUE (1 cycle): set_enable=1; set_write_en=req_write; drive tag/set/offset/size/wdata. Next state WAIT.
  - WAIT: set_enable=0, set_write_en=2. The cycle counter increments. The first matching condition wins, evaluated in order:
    - set_miss_r && load -> MEMREQ.
    - set_data_ready -> RESP with rsp_hit=~(set_miss_r|set_miss_w).
    - counter==TIMEOUT -> RESP with rsp_err=1.
  - MEMREQ: mem_req_valid=1 until mem_req_ready. mem_req_addr is held stable. Next state MEMWAIT.
  - MEMWAIT: wait for mem_rsp_valid and latch mem_rsp_data. Next state FILL.
  - FILL (1 cycle): set_enable=1, set_write_en=1, size=3, offset={offset[5:3],3'b0}, write data=fill word. Next state FILLWAIT; counter clears.
  - FILLWAIT: same as WAIT, but completion goes to RESP with rsp_hit=0 and data taken from the fill word. Timeout sets rsp_err=1.
  - RESP (1 cycle): rsp_valid=1, then IDLE.
- Load data from the Set: (set_out_data[63:0] >> 8*offset[2:0]) masked to the size, zero-extended.
- Load data from a fill: same extraction applied to the fill word.
- Store data: rsp_data=0. A write miss responds with rsp_hit=0 and no fill; the Set allocates on its own.
- Minimum load hit latency: accept -> rsp_valid in 3 cycles, with data_ready asserted the cycle after ISSUE.
- set_data_ready asserted in IDLE/RESP/MEMREQ/MEMWAIT is ignored.
- mem_rsp_valid outside MEMWAIT is ignored.
- The timeout counter is 8 bits and saturates; it clears on entering WAIT/FILLWAIT.
- rst_n asserted mid-operation: immediate return to IDLE. Any pending memory response is dropped. No rsp_valid is issued for the aborted request.

Optional Feature:
- Macro: CACHE_SET_CTRL_STATS_EN.
- When defined, adds outputs stat_hits[31:0], stat_misses[31:0] and stat_errs[31:0].
  - Each increments once per RESP according to hit, miss or err.
  - All three wrap at 2^32 and reset to 0.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Load hit: store 0xA5 size0 addr tag=16,set=0,off=0, then load the same address. Required: second rsp_valid with rsp_hit=1 and rsp_data=0x00000000000000A5, 3 cycles after accept.
- Read miss/fill: load tag=19,set=0,off=4,size2. Set asserts miss_r, and memory returns 0x1122334455667788 at addr[2:0]=0.
  - Required: mem_req_addr low bits 0.
  - Required: FILL writes size3 at offset 0.
  - Required: rsp_hit=0, rsp_data=0x11223344.
- Misaligned: load size3 at offset 2. Required: rsp_err=1 in 2 cycles, set_enable never asserted.
- Timeout: load with set_data_ready held 0. Required: rsp_err=1 exactly TIMEOUT+1 cycles after WAIT entry, then return to IDLE.
- Backpressure/reset: keep mem_req_ready=0 for 10 cycles and check mem_req_valid and addr stay stable. Then pulse rst_n low in MEMWAIT. Required: outputs return to reset values asynchronously, no rsp_valid, and req_ready=1 after release.
- Stats (macro on): 2 hits, 1 miss, 1 err. Required: counters read 2/1/1.
